// File: rtl/torpedo_launch_scheduler.sv
// Shared fire-button scheduler: debounces fire at frame rate and hands each
// launch to the next free torpedo unit round-robin, with a frame-based cooldown.
//
// state    | meaning
// IDLE     | waiting for a request; requests with no free unit count as drops
// LAUNCH   | one-hot strobe held on the selected unit for LAUNCH_LEN cycles
// COOLDOWN | counting vsyncs before the next request is accepted
module torpedo_launch_scheduler #(
  parameter int TORPEDOS        = 4,
  parameter int LAUNCH_LEN      = 4,
  parameter int COOLDOWN_FRAMES = 6,
  parameter int REPEAT_FRAMES   = 15
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            vsync,
  input  logic                            fire,
  input  logic [TORPEDOS-1:0]             t_active,
  input  logic [TORPEDOS-1:0]             t_dead,
  output logic [TORPEDOS-1:0]             launch,
  output logic [$clog2(TORPEDOS)-1:0]     launch_idx,
  output logic [$clog2(TORPEDOS+1)-1:0]   active_count,
  output logic                            busy,
  output logic [15:0]                     shots,
  output logic [7:0]                      drops
);

  localparam int IDXW = $clog2(TORPEDOS);
  localparam int CNTW = $clog2(TORPEDOS + 1);
  localparam int LLW  = (LAUNCH_LEN < 2) ? 1 : $clog2(LAUNCH_LEN);
  localparam int CDW  = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
  localparam int RPW  = (REPEAT_FRAMES < 1) ? 1 : $clog2(REPEAT_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, COOLDOWN} state_t;

  state_t              state, state_nxt;
  logic                test, fire_db, fire_db_q;
  logic [RPW-1:0]      rep_cnt;
  logic                rep_req;
  logic                req;
  logic [TORPEDOS-1:0] free, free_rot;
  logic [IDXW-1:0]     sel, sel_scan, rr;
  logic [LLW-1:0]      lcnt;
  logic [CDW-1:0]      cd_cnt;
  logic [CNTW-1:0]     act_pop;

  assign free = ~t_active & ~t_dead;
  assign req  = (fire_db & ~fire_db_q) | rep_req;

  // Rotate free so bit 0 is the slot at rr; the lowest set offset wins.
  always_comb begin
    free_rot = TORPEDOS'({free, free} >> rr);
    sel_scan = '0;
    for (int i = TORPEDOS - 1; i >= 0; i--) begin
      if (free_rot[i]) sel_scan = IDXW'((int'(rr) + i) % TORPEDOS);
    end
  end

  always_comb begin
    act_pop = '0;
    for (int i = 0; i < TORPEDOS; i++) act_pop = act_pop + CNTW'(t_active[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (req && free != '0) state_nxt = LAUNCH;
      LAUNCH:   if (lcnt == '0) state_nxt = COOLDOWN;
      COOLDOWN: if (cd_cnt == '0 || (vsync && cd_cnt == CDW'(1))) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    launch     = '0;
    launch_idx = '0;
    busy       = (state != IDLE);
    if (state == LAUNCH) begin
      launch     = TORPEDOS'(1) << sel;
      launch_idx = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      test         <= 1'b0;
      fire_db      <= 1'b0;
      fire_db_q    <= 1'b0;
      rep_cnt      <= '0;
      rep_req      <= 1'b0;
      sel          <= '0;
      rr           <= '0;
      lcnt         <= '0;
      cd_cnt       <= '0;
      shots        <= '0;
      drops        <= '0;
      active_count <= '0;
    end else begin
      fire_db_q    <= fire_db;
      active_count <= act_pop;
      rep_req      <= 1'b0;

      // A frame counts as pressed only if fire stayed high through all of it.
      if (vsync) begin
        fire_db <= test & fire;
        test    <= 1'b1;
      end else begin
        test    <= test & fire;
      end

      if (REPEAT_FRAMES != 0) begin
        if (!fire_db) begin
          rep_cnt <= '0;
        end else if (vsync) begin
          if (int'(rep_cnt) + 1 == REPEAT_FRAMES) begin
            rep_cnt <= '0;
            rep_req <= 1'b1;
          end else begin
            rep_cnt <= rep_cnt + RPW'(1);
          end
        end
      end

      case (state)
        IDLE: begin
          if (req) begin
            if (free == '0) begin
              if (drops != 8'hFF) drops <= drops + 8'd1;
            end else begin
              sel  <= sel_scan;
              lcnt <= LLW'(LAUNCH_LEN - 1);
            end
          end
        end
        LAUNCH: begin
          if (lcnt == '0) begin
            shots  <= shots + 16'd1;
            rr     <= (sel == IDXW'(TORPEDOS - 1)) ? '0 : sel + IDXW'(1);
            cd_cnt <= CDW'(COOLDOWN_FRAMES);
          end else begin
            lcnt <= lcnt - LLW'(1);
          end
        end
        COOLDOWN: begin
          if (vsync && cd_cnt != '0) cd_cnt <= cd_cnt - CDW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_torpedo_launch_scheduler.sv
// Randomized bench for torpedo_launch_scheduler against a frame-level reference model.
module tb_torpedo_launch_scheduler;

  localparam int T     = 4;
  localparam int LL    = 4;
  localparam int CD    = 6;
  localparam int RP    = 15;
  localparam int FRAME = 16;
  localparam int IW    = $clog2(T);
  localparam int CW    = $clog2(T + 1);

  logic          clk = 1'b0;
  logic          reset, vsync, fire;
  logic [T-1:0]  t_active, t_dead;
  logic [T-1:0]  launch;
  logic [IW-1:0] launch_idx;
  logic [CW-1:0] active_count;
  logic          busy;
  logic [15:0]   shots;
  logic [7:0]    drops;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  torpedo_launch_scheduler #(
    .TORPEDOS(T), .LAUNCH_LEN(LL), .COOLDOWN_FRAMES(CD), .REPEAT_FRAMES(RP)
  ) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .fire(fire),
    .t_active(t_active), .t_dead(t_dead),
    .launch(launch), .launch_idx(launch_idx), .active_count(active_count),
    .busy(busy), .shots(shots), .drops(drops)
  );

  // Reference model: mode 0 idle, 1 launching, 2 cooling down.
  int m_mode, m_left, m_cool, m_sel, m_rr, m_shots, m_drops, m_acnt, m_held;
  bit m_win, m_db, m_req;

  int cyc = 0;
  bit dead_en = 0;
  bit prev_nz = 0;
  int starts[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    logic [T-1:0] fr;
    bit new_db, new_req, found;
    if (reset) begin
      m_mode = 0; m_left = 0; m_cool = 0; m_sel = 0; m_rr = 0;
      m_shots = 0; m_drops = 0; m_acnt = 0; m_held = 0;
      m_win = 0; m_db = 0; m_req = 0;
      return;
    end
    m_acnt = $countones(t_active);
    case (m_mode)
      0: if (m_req) begin
        fr = ~t_active & ~t_dead;
        if (fr == '0) begin
          if (m_drops < 255) m_drops++;
        end else begin
          found = 0;
          for (int k = 0; k < T; k++) begin
            if (!found && fr[(m_rr + k) % T]) begin
              m_sel = (m_rr + k) % T;
              found = 1;
            end
          end
          m_mode = 1;
          m_left = LL;
        end
      end
      1: begin
        m_left--;
        if (m_left == 0) begin
          m_shots = (m_shots + 1) % 65536;
          m_rr    = (m_sel + 1) % T;
          m_cool  = CD;
          m_mode  = 2;
        end
      end
      default: begin
        if (m_cool == 0) m_mode = 0;
        else if (vsync) begin
          m_cool--;
          if (m_cool == 0) m_mode = 0;
        end
      end
    endcase
    new_req = 0;
    if (vsync) begin
      new_db = m_win && fire;
      if (RP != 0 && m_db) begin
        m_held++;
        if (m_held == RP) begin new_req = 1; m_held = 0; end
      end else begin
        m_held = 0;
      end
      if (new_db && !m_db) new_req = 1;
      m_db  = new_db;
      m_win = 1;
    end else begin
      m_win = m_win && fire;
    end
    m_req = new_req;
  endtask

  task automatic tick();
    int exp_l;
    @(posedge clk);
    #1;
    model_edge();
    exp_l = (m_mode == 1) ? (1 << m_sel) : 0;
    check("launch", 32'(launch), exp_l);
    check("launch_idx", 32'(launch_idx), (m_mode == 1) ? m_sel : 0);
    check("active_count", 32'(active_count), m_acnt);
    check("busy", 32'(busy), (m_mode != 0) ? 1 : 0);
    check("shots", 32'(shots), m_shots);
    check("drops", 32'(drops), m_drops);
    if (launch != '0 && !prev_nz) starts.push_back(int'(launch_idx));
    prev_nz = (launch != '0);
    cyc++;
    vsync  = (cyc % FRAME == 0);
    t_dead = (dead_en && $urandom_range(0, 15) == 0) ? T'($urandom) : '0;
  endtask

  task automatic align();
    do tick(); while (!vsync);
    tick();
  endtask

  task automatic hold(input int frames, input bit f);
    fire = f;
    repeat (frames * FRAME) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  initial begin
    int d0, s0, waited, on, g, mode;
    reset = 1'b1; vsync = 1'b0; fire = 1'b0; t_active = '0; t_dead = '0;
    repeat (3) tick();
    reset = 1'b0;

    // First press after reset, all units free.
    starts.delete();
    align();
    hold(10, 1'b1);
    hold(8, 1'b0);
    check("A_nlaunch", starts.size(), 1);
    check("A_idx", (starts.size() > 0) ? starts[0] : 99, 0);
    check("A_shots", 32'(shots), 1);

    // Unit 0 flying: rotation 1,2,3, then 0 once it lands.
    starts.delete();
    t_active = 4'b0001;
    repeat (3) begin hold(2, 1'b1); hold(8, 1'b0); end
    t_active = 4'b0000;
    hold(2, 1'b1); hold(8, 1'b0);
    check("B_nlaunch", starts.size(), 4);
    for (int k = 0; k < 4; k++)
      check("B_idx", (starts.size() > k) ? starts[k] : 99, (k + 1) % 4);

    // No free unit: drops accumulate and saturate.
    t_active = 4'b1111;
    repeat (260) begin hold(1, 1'b0); hold(2, 1'b1); end
    hold(2, 1'b0);
    check("C_drops_sat", 32'(drops), 8'hFF);

    // Press landing inside cooldown is discarded, not dropped.
    t_active = 4'b0000;
    d0 = m_drops; s0 = m_shots;
    hold(2, 1'b1); hold(1, 1'b0); hold(3, 1'b1); hold(8, 1'b0);
    check("D_shots", 32'(shots), s0 + 1);
    check("D_drops", 32'(drops), d0);

    // Auto-repeat while held, from a fresh reset.
    do_reset();
    starts.delete();
    align();
    hold(58, 1'b1);
    hold(4, 1'b0);
    check("E_nlaunch", starts.size(), 4);
    for (int k = 0; k < 4; k++)
      check("E_idx", (starts.size() > k) ? starts[k] : 99, k);

    // Reset on the second cycle of a launch strobe.
    do_reset();
    align();
    fire = 1'b1;
    waited = 0;
    while (!(m_mode == 1 && m_left == LL - 1) && waited < 10 * FRAME) begin
      tick();
      waited++;
    end
    check("F_reached_launch", (waited < 10 * FRAME) ? 1 : 0, 1);
    fire  = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("F_launch_cut", 32'(launch), 0);
    check("F_shots", 32'(shots), 0);
    check("F_busy", 32'(busy), 0);
    starts.delete();
    align();
    hold(2, 1'b1); hold(8, 1'b0);
    check("F_nlaunch", starts.size(), 1);
    check("F_idx", (starts.size() > 0) ? starts[0] : 99, 0);

    // Random traffic with glitches and death pulses.
    dead_en = 1;
    repeat (300) begin
      t_active = T'($urandom);
      mode = $urandom_range(0, 3);
      on   = (mode != 0) ? 1 : 0;
      g    = $urandom_range(0, FRAME - 1);
      for (int c = 0; c < FRAME; c++) begin
        fire = (mode == 3 && c == g) ? 1'b0 : on[0];
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/torpedo_launch_scheduler.md
Name: torpedo_launch_scheduler

Overview:
- Owns the shared fire button and allocates launches across a pool of TORPEDOS torpedo units, which replaces per-unit fire cascading.
- Debounces fire at frame rate and detects the press edge, with optional auto-repeat while the button is held.
- Picks a free unit round-robin, drives a one-hot launch strobe to that unit, and enforces a frame-based cooldown.
- Sits between the input/keys block and the torpedo units; tracks in-flight torpedoes and keeps shot and drop statistics.

Parameters:
- TORPEDOS, 4, number of torpedo units managed (2..8).
- LAUNCH_LEN, 4, cycles the launch strobe is held; must cover a unit's 3-cycle sin/cos capture pipeline.
- COOLDOWN_FRAMES, 6, minimum vsync pulses between launches.
- REPEAT_FRAMES, 15, frames between auto-repeat launches while fire is held; 0 disables auto-repeat.

Ports:
- clk  in  1  system clock (pixel clock domain).
- reset  in  1  reset; synchronous, active-high.
- vsync  in  1  one-cycle pulse, once per frame.
- fire  in  1  raw fire button, active-high.
- t_active  in  TORPEDOS  per-unit "torpedo flying" flag.
- t_dead  in  TORPEDOS  per-unit one-cycle death pulse.
- launch  out  TORPEDOS  one-hot launch strobe.
- launch_idx  out  $clog2(TORPEDOS)  index of the unit being launched; valid while launch!=0.
- active_count  out  $clog2(TORPEDOS+1)  popcount of t_active, registered.
- busy  out  1  high in the LAUNCH or COOLDOWN state.
- shots  out  16  total launches, wraps at 16'hFFFF->0.
- drops  out  8  requests lost because no unit was free; saturates at 8'hFF.

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values: launch=0, launch_idx=0, active_count=0, busy=0, shots=0, drops=0. Round-robin pointer rr=0, state IDLE, debounce regs=0.
- Reset mid-LAUNCH: launch drops to 0 on the next edge. The torpedo unit must tolerate a truncated strobe.
- Debounce:
  - test latch is ANDed with fire every cycle.
  - On vsync: fire_db <= test and test <= 1.
  - A request is fire_db rising, i.e. fire_db=1 with the previous fire_db=0.
- Auto-repeat:
  - Applies only when REPEAT_FRAMES != 0.
  - rep_cnt counts vsyncs while fire_db=1 and clears when fire_db=0.
  - When rep_cnt reaches REPEAT_FRAMES it raises a request and reloads to 0.
- States:
  - IDLE:
    - On request, evaluate free = ~t_active & ~t_dead.
    - If free==0: drops++ and stay in IDLE.
    - Otherwise: sel = first set bit of free scanning rr, rr+1, …, wrapping modulo TORPEDOS. Register sel, go to LAUNCH.
  - LAUNCH:
    - launch = 1<<sel and launch_idx = sel, both for exactly LAUNCH_LEN cycles, starting the cycle after the request.
    - On exit: shots++, rr <= (sel+1) mod TORPEDOS, cd_cnt <= COOLDOWN_FRAMES, go to COOLDOWN.
  - COOLDOWN:
    - Decrement cd_cnt on each vsync; go to IDLE when it hits 0.
    - If COOLDOWN_FRAMES=0, go to IDLE the next cycle.
    - Requests arriving here are discarded and are not counted as drops.
- Request is a single-cycle internal pulse and is never queued.
- A t_dead pulse in the same cycle as selection makes that slot not free.
- active_count has one cycle of latency from t_active.
- launch is registered; there is no combinational path from fire or t_active to launch.

Test Plan:
- Reset, fire held 2 frames, t_active=0 -> launch=4'b0001 for 4 cycles starting 1 cycle after the fire_db rise; shots=1; busy low 6 vsyncs later.
- Three presses spaced 10 frames, unit 0 still flying -> launches on idx 1, 2, 3, then 0 after t_active[0] clears; rr wraps correctly.
- t_active=4'b1111, press -> no launch, drops=1; 255 further drops -> drops stays 8'hFF.
- Press during COOLDOWN (frame 3 of 6) -> no launch, drops unchanged, shots unchanged.
- Hold fire 60 frames with REPEAT_FRAMES=15, all free -> 4 launches at frames 0, 15, 30, 45 relative to the first; idx 0, 1, 2, 3.
- Assert reset on cycle 2 of LAUNCH -> launch=0 next cycle, shots=0, state IDLE; next press launches idx 0.
